// File: rtl/regfile_pkg.sv
// Shared types, constants and write-port priority helper for the register file.
package regfile_pkg;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   localparam int unsigned XLEN_DEF  = 64;
   localparam int unsigned DEPTH_DEF = 32;
   localparam int unsigned ZERO_ADDR = 0;

   // Upper bound on write ports the selector can resolve.
   localparam int unsigned MAX_WR = 16;
   localparam int unsigned WSEL_W = 4;

   typedef struct packed {
      logic              hit;
      logic [WSEL_W-1:0] idx;
   } wsel_t;

   // Highest-index set bit of match wins; hit reports whether any bit was set.
   function automatic wsel_t wr_select(input logic [MAX_WR-1:0] match);
      wsel_t s;
      s = '0;
      for (int unsigned i = 0; i < MAX_WR; i++) begin
         if (match[i]) begin
            s.hit = 1'b1;
            s.idx = i[WSEL_W-1:0];
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set by issue, cleared by writeback, set wins on collision.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned NWR   = 2,
   parameter int unsigned NRD   = 3,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NWR-1:0]    clr_en,
   input  logic [NWR*AW-1:0] clr_addr,
   input  logic              set_en,
   input  logic [AW-1:0]     set_addr,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    rd_pend
);

   logic [DEPTH-1:0] pend;
   logic [DEPTH-1:0] pend_nxt;

   // Clears first, then the set, so a same-cycle set overrides a clear; bit 0 is forced low.
   always_comb begin
      pend_nxt = pend;
      for (int unsigned w = 0; w < NWR; w++) begin
         if (clr_en[w]) pend_nxt[clr_addr[w*AW +: AW]] = 1'b0;
      end
      if (set_en) pend_nxt[set_addr] = 1'b1;
      pend_nxt[ZERO_ADDR] = 1'b0;
   end

   // Pending vector register, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) pend <= '0;
      else     pend <= pend_nxt;
   end

   // Raw pending lookup per read port.
   always_comb begin
      rd_pend = '0;
      for (int unsigned r = 0; r < NRD; r++) begin
         rd_pend[r] = pend[rd_addr[r*AW +: AW]];
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, zero register, scoreboard and clear engine.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned NRD   = 3,
   parameter int unsigned NWR   = 2,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_pend,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                sb_set,
   input  logic [AW-1:0]       sb_addr,
   output logic                ready
);

   state_t          state, state_nxt;
   logic [AW-1:0]   cnt, cnt_nxt;
   logic            run;
   logic [XLEN-1:0] mem [DEPTH];
   logic [NRD-1:0]  sb_pend;
   logic [NWR-1:0]  sb_clr;

   assign run   = (state == RUN);
   assign ready = run;

   // Clear engine: walk cnt through every entry, then enter RUN.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == INIT) begin
         cnt_nxt = cnt + 1'b1;
         if (cnt == AW'(DEPTH-1)) state_nxt = RUN;
      end
   end

   // State and clear counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Storage has no reset value; INIT zeroes it, RUN writes in ascending port order so the highest port lands last.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            mem[cnt] <= '0;
         end else begin
            for (int unsigned w = 0; w < NWR; w++) begin
               if (wr_en[w] && (wr_addr[w*AW +: AW] != AW'(ZERO_ADDR)))
                  mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
            end
         end
      end
   end

   assign sb_clr = wr_en & {NWR{run}};

   regfile_scoreboard #(
      .DEPTH (DEPTH),
      .NWR   (NWR),
      .NRD   (NRD)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .clr_en   (sb_clr),
      .clr_addr (wr_addr),
      .set_en   (sb_set & run),
      .set_addr (sb_addr),
      .rd_addr  (rd_addr),
      .rd_pend  (sb_pend)
   );

   // Read ports: zero register, then bypass from the highest matching write port, then storage.
   always_comb begin
      logic [MAX_WR-1:0] match;
      logic [AW-1:0]     ra;
      wsel_t             sel;
      rd_data = '0;
      rd_pend = '0;
      for (int unsigned r = 0; r < NRD; r++) begin
         ra    = rd_addr[r*AW +: AW];
         match = '0;
         for (int unsigned w = 0; w < NWR; w++) begin
            match[w] = wr_en[w] && (wr_addr[w*AW +: AW] == ra);
         end
         sel = wr_select(match);
         if (run && (ra != AW'(ZERO_ADDR))) begin
            if (sel.hit) begin
               rd_data[r*XLEN +: XLEN] = wr_data[int'(sel.idx)*XLEN +: XLEN];
            end else begin
               rd_data[r*XLEN +: XLEN] = mem[ra];
               rd_pend[r]              = sb_pend[r];
            end
         end
      end
   end

endmodule
